// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM states, memory geometry
// and the accumulator CPU opcode set.
package prog_loader_pkg;

    localparam int MEM_DEPTH = 16;
    localparam int ADDR_W    = 4;
    localparam int CNT_W     = 5;

    localparam logic [3:0] OP_LOAD = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_HALT = 4'b1010;

    localparam logic [3:0] HALT_OPCODE = OP_HALT;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_WRITE,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/prog_loader.sv
// Program loader: assembles a byte stream into 12-bit instruction words,
// writes them into the accumulator CPU's instruction memory, and holds the
// CPU in reset until the load session ends.
module prog_loader #(
    parameter int         MEM_DEPTH   = prog_loader_pkg::MEM_DEPTH,
    parameter logic [3:0] HALT_OPCODE = prog_loader_pkg::HALT_OPCODE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        we,
    output logic [3:0]  instr_addr,
    output logic [11:0] instr_in,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic [4:0]  word_count
);

    import prog_loader_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    state_t     state;
    logic [3:0] opcode;

    // Stream handshake and activity flag come straight from the state register.
    assign s_ready = (state == ST_HI) || (state == ST_LO);
    assign busy    = (state != ST_IDLE);

    // Load-session FSM with all CPU-facing outputs registered.
    // NOTE: every register here, state included, uses <= so all of them
    // update together from the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: reset only clears a handful of control/data registers; there
        // is no memory array in this block, the instruction RAM lives in the CPU.
        if (!reset) begin
            state      <= ST_IDLE;
            we         <= 1'b0;
            instr_addr <= '0;
            instr_in   <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            word_count <= '0;
            opcode     <= '0;
        end else begin
            // we and done are single-cycle pulses unless a state re-asserts them.
            we   <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_HI;
                        word_count <= '0;
                        instr_addr <= '0;
                        cpu_reset  <= 1'b1;
                    end
                end
                ST_HI: begin
                    if (s_valid) begin
                        opcode <= s_data[3:0];
                        state  <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (s_valid) begin
                        instr_in <= {opcode, s_data};
                        we       <= 1'b1;
                        state    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    word_count <= word_count + 5'd1;
                    // The last memory slot always ends the session, so the
                    // address never wraps back over word 0.
                    if ((opcode == HALT_OPCODE) || (instr_addr == LAST_ADDR)) begin
                        cpu_reset <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_FINISH;
                    end else begin
                        instr_addr <= instr_addr + 4'd1;
                        state      <= ST_HI;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a byte-list model predicts the write
// sequence, a per-cycle monitor compares the DUT against it, and directed
// sessions cover halt, full-memory, stalls, start noise and abort.
module tb_prog_loader;

    localparam logic [3:0] HALT = 4'b1010;

    logic        clk;
    logic        reset;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        we;
    logic [3:0]  instr_addr;
    logic [11:0] instr_in;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic [4:0]  word_count;

    prog_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .we         (we),
        .instr_addr (instr_addr),
        .instr_in   (instr_in),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: byte program, predicted writes, predicted final count.
    logic [7:0]  byte_q[$];
    logic [3:0]  exp_addr_q[$];
    logic [11:0] exp_data_q[$];
    int          exp_wc;
    int          n_send;

    // Monitor state.
    int          done_cnt  = 0;
    int          wr_seen   = 0;
    bit          rel       = 0;
    bit          prev_busy = 0;
    logic [11:0] cpu_mem [16];

    // Pair bytes into words; a session stops at a HALT opcode or at the 16th word.
    task automatic build_expect();
        logic [3:0] op;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_wc = 0;
        n_send = 0;
        for (int i = 0; i + 1 < byte_q.size(); i += 2) begin
            op = byte_q[i][3:0];
            exp_addr_q.push_back(4'(i / 2));
            exp_data_q.push_back({op, byte_q[i + 1]});
            exp_wc++;
            n_send = i + 2;
            if (op == HALT || (i / 2) == 15) break;
        end
    endtask

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (!reset) begin
            check("rst_we", we, 0);
            check("rst_cpu_reset", cpu_reset, 1);
            check("rst_word_count", word_count, 0);
            check("rst_done", done, 0);
            wr_seen   = 0;
            rel       = 0;
            prev_busy = 0;
        end else begin
            if (busy && !prev_busy) begin
                wr_seen = 0;
                rel     = 0;
            end
            check("word_count", word_count, wr_seen);
            if (!busy)
                check("idle_cpu_reset", cpu_reset, rel ? 0 : 1);
            else if (!done)
                check("busy_cpu_reset", cpu_reset, 1);
            if (we) begin
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    check("wr_addr", instr_addr, exp_addr_q.pop_front());
                    check("wr_data", instr_in, exp_data_q.pop_front());
                end
                cpu_mem[instr_addr] = instr_in;
                wr_seen++;
            end
            if (done) begin
                done_cnt++;
                check("done_cpu_reset", cpu_reset, 0);
                check("done_word_count", word_count, exp_wc);
                check("done_pending_writes", exp_addr_q.size(), 0);
                rel = 1;
            end
            prev_busy = busy;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        t = 0;
        while (!s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) check("byte_accept_timeout", 0, 1);
        else @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_bytes(input int max_gap);
        for (int i = 0; i < n_send; i++)
            send_byte(byte_q[i], i % (max_gap + 1));
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_session(input int max_gap, input bit pulse_start);
        int d0;
        int t;
        d0 = done_cnt;
        do_start();
        if (pulse_start) begin
            fork
                send_bytes(max_gap);
                begin
                    repeat (3) begin
                        repeat (4) @(negedge clk);
                        start = 1'b1;
                        @(negedge clk);
                        start = 1'b0;
                    end
                end
            join
        end else begin
            send_bytes(max_gap);
        end
        t = 0;
        while (done_cnt == d0 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (done_cnt == d0) check("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
        check("done_pulse_count", done_cnt, d0 + 1);
    endtask

    task automatic load_example();
        byte_q = '{8'h01, 8'h03, 8'h02, 8'h05, 8'h03, 8'h02, 8'h0A, 8'h00};
        build_expect();
    endtask

    initial begin
        int ac;
        int pc;
        logic [3:0] op;

        reset   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state.
        check("r_we", we, 0);
        check("r_addr", instr_addr, 0);
        check("r_instr", instr_in, 0);
        check("r_cpu_reset", cpu_reset, 1);
        check("r_done", done, 0);
        check("r_word_count", word_count, 0);
        check("r_busy", busy, 0);
        check("r_s_ready", s_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_cpu_reset", cpu_reset, 1);

        // Four-word program ending in HALT, then execute it on a CPU model.
        load_example();
        check("model_w0", exp_data_q[0], 12'h103);
        check("model_w1", exp_data_q[1], 12'h205);
        check("model_w2", exp_data_q[2], 12'h302);
        check("model_w3", exp_data_q[3], 12'hA00);
        check("model_wc", exp_wc, 4);
        run_session(0, 1'b0);
        check("t1_word_count", word_count, 4);
        check("t1_cpu_released", cpu_reset, 0);
        ac = 0;
        pc = 0;
        for (int k = 0; k < 16; k++) begin
            op = cpu_mem[pc][11:8];
            if (op == HALT) break;
            case (op)
                4'b0001: ac = int'(cpu_mem[pc][7:0]);
                4'b0010: ac = ac + int'(cpu_mem[pc][7:0]);
                4'b0011: ac = ac - int'(cpu_mem[pc][7:0]);
                default: ;
            endcase
            pc++;
        end
        check("cpu_ac", ac, 6);
        check("cpu_pc", pc, 3);

        // Sixteen non-HALT words fill memory and end the session.
        byte_q.delete();
        repeat (16) begin
            byte_q.push_back(8'h01);
            byte_q.push_back(8'h00);
        end
        build_expect();
        check("model16_wc", exp_wc, 16);
        run_session(0, 1'b0);
        check("t2_word_count", word_count, 16);
        check("t2_last_word", cpu_mem[15], 12'h100);
        s_valid = 1'b1;
        s_data  = 8'h01;
        repeat (6) @(negedge clk);
        s_valid = 1'b0;
        check("t2_no_17th", word_count, 16);

        // Stalled stream with start pulsed mid-session.
        load_example();
        run_session(3, 1'b1);
        check("t3_word_count", word_count, 4);

        // High nibble of the opcode byte is ignored: FA becomes HALT.
        byte_q = '{8'hFA, 8'h00, 8'h01, 8'h02};
        build_expect();
        check("model_fa_wc", exp_wc, 1);
        check("model_fa_w0", exp_data_q[0], 12'hA00);
        run_session(0, 1'b0);
        check("t4_word_count", word_count, 1);

        // Reset after the second word aborts the session.
        byte_q = '{8'h01, 8'h11, 8'h02, 8'h22};
        build_expect();
        do_start();
        send_bytes(0);
        send_byte(8'h03, 0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_we", we, 0);
        check("abort_cpu_reset", cpu_reset, 1);
        check("abort_word_count", word_count, 0);
        check("abort_busy", busy, 0);
        repeat (2) @(negedge clk);
        check("abort_writes_done", exp_addr_q.size(), 0);
        reset = 1'b1;
        @(negedge clk);
        load_example();
        run_session(0, 1'b0);
        check("t5_word_count", word_count, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
